vending_machine: RTL and testbench

//   Coin-operated vending controller. Accepts nickels (5c) and dimes (10c) and

---
 rtl/vending_pkg.sv | 22 ++
 rtl/vending_price_lut.sv | 14 +
 rtl/vending_machine.sv | 85 ++++++++
 tb/tb_vending_machine.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller.
// Prices and credit are counted in nickels throughout.
package vending_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam logic [1:0] NICKEL_VAL = 2'd1;
  localparam logic [1:0] DIME_VAL   = 2'd2;

  // The price steps once per group of four items, selected by item_number[3:2].
  function automatic logic [2:0] price_nickels(input logic [3:0]  item_number,
                                               input int unsigned base,
                                               input int unsigned step);
    int unsigned p;
    p = base + step * int'(item_number >> 2);
    return p[2:0];
  endfunction

endpackage

// File: rtl/vending_price_lut.sv
// Combinational item -> price lookup, with the price given in nickels.
module vending_price_lut
  import vending_pkg::*;
#(
  parameter int unsigned BASE_NICKELS = 2,
  parameter int unsigned STEP_NICKELS = 1
) (
  input  logic [3:0] item_i,
  output logic [2:0] price_o
);

  assign price_o = price_nickels(item_i, BASE_NICKELS, STEP_NICKELS);

endmodule

// File: rtl/vending_machine.sv
// Coin-operated vending controller: accumulates nickel/dime credit against a
// price latched on the first coin, then pulses dispense and, when needed, change.
module vending_machine
  import vending_pkg::*;
#(
  parameter int unsigned BASE_NICKELS = 2,
  parameter int unsigned STEP_NICKELS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] item_number,
  input  logic       nickel_in,
  input  logic       dime_in,
  output logic       nickel_out,
  output logic       dispense
);

  state_e     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [2:0] price_q, price_d;
  logic       dispense_q, dispense_d;
  logic       nickel_out_q, nickel_out_d;

  logic [2:0] lut_price;
  logic [2:0] eff_price;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic [3:0] sum;

  vending_price_lut #(
    .BASE_NICKELS(BASE_NICKELS),
    .STEP_NICKELS(STEP_NICKELS)
  ) u_price_lut (
    .item_i (item_number),
    .price_o(lut_price)
  );

  // Both coin lines high at once is an invalid reading and counts as no coin.
  assign coin_valid = nickel_in ^ dime_in;
  assign coin_val   = dime_in ? DIME_VAL : NICKEL_VAL;
  assign eff_price  = (state_q == IDLE) ? lut_price : price_q;
  assign sum        = {1'b0, credit_q} + {2'b00, coin_val};

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path leaves it unassigned (no latch).
    state_d      = state_q;
    credit_d     = credit_q;
    price_d      = price_q;
    dispense_d   = 1'b0;
    nickel_out_d = 1'b0;
    if (coin_valid) begin
      price_d = eff_price;
      if (sum < {1'b0, eff_price}) begin
        credit_d = sum[2:0];
        state_d  = COLLECT;
      end else begin
        credit_d     = '0;
        state_d      = IDLE;
        dispense_d   = 1'b1;
        nickel_out_d = (sum != {1'b0, eff_price});
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      price_q      <= '0;
      dispense_q   <= 1'b0;
      nickel_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      price_q      <= price_d;
      dispense_q   <= dispense_d;
      nickel_out_q <= nickel_out_d;
    end
  end

  assign dispense   = dispense_q;
  assign nickel_out = nickel_out_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios followed by random
// coin traffic, compared against a cents-based transaction model.
module tb_vending_machine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] item_number = 4'd0;
  logic       nickel_in = 1'b0;
  logic       dime_in = 1'b0;
  wire        nickel_out;
  wire        dispense;

  int total = 0;
  int bad   = 0;

  // Reference model state, in cents.
  int   credit_c = 0;
  int   price_c  = 0;
  logic exp_disp = 1'b0;
  logic exp_nout = 1'b0;

  always #5 clock = ~clock;

  vending_machine dut (
    .clock      (clock),
    .reset      (reset),
    .item_number(item_number),
    .nickel_in  (nickel_in),
    .dime_in    (dime_in),
    .nickel_out (nickel_out),
    .dispense   (dispense)
  );

  task automatic check(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic model_edge(input logic n, input logic d, input logic [3:0] item);
    exp_disp = 1'b0;
    exp_nout = 1'b0;
    if (n != d) begin
      if (credit_c == 0) price_c = 10 + 5 * int'(item[3:2]);
      credit_c += d ? 10 : 5;
      if (credit_c >= price_c) begin
        exp_disp = 1'b1;
        exp_nout = ((credit_c - price_c) == 5);
        credit_c = 0;
      end
    end
  endtask

  // One sampled edge: drive on the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic n, input logic d, input logic [3:0] item);
    @(negedge clock);
    nickel_in   = n;
    dime_in     = d;
    item_number = item;
    model_edge(n, d, item);
    @(posedge clock);
    #1;
    check({tag, ".dispense"}, dispense, exp_disp);
    check({tag, ".nickel_out"}, nickel_out, exp_nout);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    nickel_in = 1'b0;
    dime_in   = 1'b0;
    reset     = 1'b1;
    credit_c  = 0;
    #1;
    check({tag, ".dispense"}, dispense, 1'b0);
    check({tag, ".nickel_out"}, nickel_out, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Assert reset asynchronously, between clock edges, and check outputs drop at once.
  task automatic async_reset(input string tag);
    #2;
    reset    = 1'b1;
    credit_c = 0;
    #1;
    check({tag, ".dispense"}, dispense, 1'b0);
    check({tag, ".nickel_out"}, nickel_out, 1'b0);
    @(negedge clock);
    nickel_in = 1'b0;
    dime_in   = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    logic [2:0] r;
    logic [3:0] it;

    // Reset, idle, then a nickel acts as the first coin of a transaction.
    pulse_reset("reset");
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 4'd0);
    step("first_nickel", 1'b1, 1'b0, 4'd0);
    step("second_nickel", 1'b1, 1'b0, 4'd0);
    step("after_pulse", 1'b0, 1'b0, 4'd0);

    // 15c item: nickel + dime, twice back to back.
    step("i4_n", 1'b1, 1'b0, 4'd4);
    step("i4_d", 1'b0, 1'b1, 4'd4);
    step("i4_n2", 1'b1, 1'b0, 4'd4);
    step("i4_d2", 1'b0, 1'b1, 4'd4);
    step("i4_idle", 1'b0, 1'b0, 4'd4);

    // 10c item: exact dime, then nickel + dime with change.
    step("i0_d", 1'b0, 1'b1, 4'd0);
    step("i0_n", 1'b1, 1'b0, 4'd0);
    step("i0_d_change", 1'b0, 1'b1, 4'd0);
    step("i0_idle", 1'b0, 1'b0, 4'd0);

    // 25c item: exact, then overpay by 5c.
    step("i12_d1", 1'b0, 1'b1, 4'd12);
    step("i12_d2", 1'b0, 1'b1, 4'd12);
    step("i12_n", 1'b1, 1'b0, 4'd12);
    step("i12_d3", 1'b0, 1'b1, 4'd12);
    step("i12_d4", 1'b0, 1'b1, 4'd12);
    step("i12_d5", 1'b0, 1'b1, 4'd12);

    // Price latched at 20c even though the selection changes mid-transaction.
    step("i8_n", 1'b1, 1'b0, 4'd8);
    step("latch_n2", 1'b1, 1'b0, 4'd0);
    step("latch_n3", 1'b1, 1'b0, 4'd0);
    step("latch_n4", 1'b1, 1'b0, 4'd0);
    step("latch_idle", 1'b0, 1'b0, 4'd0);

    // Simultaneous coins are ignored.
    step("both", 1'b1, 1'b1, 4'd0);
    step("both_n1", 1'b1, 1'b0, 4'd0);
    step("both_n2", 1'b1, 1'b0, 4'd0);

    // Async reset during a dispense pulse, then with 10c credit held.
    step("pre_rst_d", 1'b0, 1'b1, 4'd0);
    async_reset("rst_pulse");
    step("rst_i8_d", 1'b0, 1'b1, 4'd8);
    async_reset("rst_credit");
    step("post_rst_d1", 1'b0, 1'b1, 4'd8);
    step("post_rst_d2", 1'b0, 1'b1, 4'd8);
    step("post_rst_idle", 1'b0, 1'b0, 4'd8);

    // Random coin traffic, including idle and invalid double-coin edges.
    for (int i = 0; i < 400; i++) begin
      r  = 3'($urandom_range(0, 7));
      it = 4'($urandom_range(0, 15));
      if (r < 3)      step("rand", 1'b1, 1'b0, it);
      else if (r < 6) step("rand", 1'b0, 1'b1, it);
      else if (r == 6) step("rand", 1'b0, 1'b0, it);
      else            step("rand", 1'b1, 1'b1, it);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
